// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, reads inst_mem, buffers returned words in a small FIFO
// and hands them to decode over valid/ready. Optional counters under INST_FETCH_PERF_EN.
module inst_fetch #(
  parameter int unsigned       ADDR_W     = 10,
  parameter int unsigned       DATA_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int unsigned       FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset_b,
  output logic [ADDR_W-1:0] read_addr,
  input  logic [DATA_W-1:0] read_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc
`ifdef INST_FETCH_PERF_EN
  ,
  output logic [15:0]       fetch_count,
  output logic [15:0]       stall_count
`endif
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(FIFO_DEPTH);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] req_pc_q;
  logic              req_q;
  logic [CNT_W-1:0]  count_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [DATA_W-1:0] data_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] pcbuf_q [FIFO_DEPTH];

  logic              pop;
  logic              push;
  logic              issue;
  logic [CNT_W:0]    credit_used;

  assign read_addr  = pc_q;
  assign inst_valid = (count_q != '0);
  assign inst_data  = data_q[rd_ptr_q];
  assign inst_pc    = pcbuf_q[rd_ptr_q];

  // Credits cover buffered words plus the one in flight, so a returning word always has a slot.
  always_comb begin
    pop         = inst_valid & inst_ready & ~redirect_valid;
    push        = req_q & ~redirect_valid;
    credit_used = {1'b0, count_q} + (CNT_W + 1)'(req_q)
                - (CNT_W + 1)'(inst_valid & inst_ready);
    issue       = ~redirect_valid & (credit_used < DEPTH_L);
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      pc_q     <= RESET_PC;
      req_q    <= 1'b0;
      req_pc_q <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i]  <= '0;
        pcbuf_q[i] <= '0;
      end
    end else if (redirect_valid) begin
      pc_q     <= redirect_pc;
      req_q    <= 1'b0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (issue) begin
        pc_q     <= pc_q + ADDR_W'(1);
        req_q    <= 1'b1;
        req_pc_q <= pc_q;
      end else begin
        req_q    <= 1'b0;
      end
      if (push) begin
        data_q[wr_ptr_q]  <= read_data;
        pcbuf_q[wr_ptr_q] <= req_pc_q;
        wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

`ifdef INST_FETCH_PERF_EN
  logic [15:0] fetch_q;
  logic [15:0] stall_q;

  assign fetch_count = fetch_q;
  assign stall_count = stall_q;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      fetch_q <= '0;
      stall_q <= '0;
    end else begin
      if (pop && fetch_q != '1) begin
        fetch_q <= fetch_q + 16'd1;
      end
      if (inst_valid && !inst_ready && stall_q != '1) begin
        stall_q <= stall_q + 16'd1;
      end
    end
  end
`endif

endmodule
